// File: rtl/dsp_mem_datapath.sv
// Two-stage DSP datapath, 4x16 memory and tick-latched display register; P latency 2 edges, douta 1 edge, no backpressure.
// Define DISPLAY_MEM_SOURCE_EN to latch douta into display_value on tick instead of P[15:0].
module dsp_mem_datapath #(
  parameter int TICK_COUNT = 100000000
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [6:0]  A,
  input  logic [7:0]  B,
  input  logic [6:0]  C,
  input  logic [6:0]  D,
  input  logic        carryin,
  input  logic [1:0]  select,
  input  logic        mem_we,
  input  logic [15:0] mem_wdata,
  output logic [47:0] P,
  output logic [15:0] douta,
  output logic [1:0]  mem_addr,
  output logic        tick,
  output logic [15:0] display_value
);

  localparam logic [26:0] TICK_LAST = 27'(TICK_COUNT - 1);

  logic [6:0]  a_q, c_q, d_q;
  logic [7:0]  b_q;
  logic        cin_q;
  logic [1:0]  sel_q;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      cin_q <= 1'b0;
      sel_q <= '0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      c_q   <= C;
      d_q   <= D;
      cin_q <= carryin;
      sel_q <= select;
    end
  end

  logic [47:0] a_ext, b_ext, c_ext, d_ext, cin_ext, ad_sum, p_d, p_q;

  always_comb begin
    a_ext   = {41'd0, a_q};
    b_ext   = {40'd0, b_q};
    c_ext   = {41'd0, c_q};
    d_ext   = {41'd0, d_q};
    cin_ext = {47'd0, cin_q};
    ad_sum  = a_ext + d_ext;
    p_d     = '0;
    case (sel_q)
      2'b00:   p_d = a_ext * b_ext + c_ext;
      2'b01:   p_d = a_ext * b_ext;
      2'b10:   p_d = {40'd0, ad_sum[7:0]};
      default: p_d = ad_sum * b_ext + c_ext + cin_ext;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign P = p_q;

  logic [26:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == TICK_LAST);
  assign cnt_d = tick ? 27'd0 : cnt_q + 27'd1;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Memory array is deliberately outside reset; douta is read-first on a same-address write.
  logic [15:0] mem_q [0:3];
  logic [15:0] douta_q;
  logic [1:0]  addr_q, addr_d;

  always_ff @(posedge clock_100Mhz) begin
    if (mem_we) mem_q[addr_q] <= mem_wdata;
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) douta_q <= '0;
    else       douta_q <= mem_q[addr_q];
  end

  assign addr_d   = tick ? addr_q + 2'd1 : addr_q;
  assign douta    = douta_q;
  assign mem_addr = addr_q;

  logic [15:0] disp_src, disp_d, disp_q;

`ifdef DISPLAY_MEM_SOURCE_EN
  assign disp_src = douta_q;
`else
  assign disp_src = p_q[15:0];
`endif

  assign disp_d = tick ? disp_src : disp_q;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      disp_q <= '0;
    end else begin
      addr_q <= addr_d;
      disp_q <= disp_d;
    end
  end

  assign display_value = disp_q;

endmodule

// File: tb/tb_dsp_mem_datapath.sv
// Bench for dsp_mem_datapath: DSP results via an expected-value queue, tick/memory/display by cycle counting.
module tb_dsp_mem_datapath;

  localparam int TC = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  a, c, d;
  logic [7:0]  b;
  logic        cin;
  logic [1:0]  sel;
  logic        we;
  logic [15:0] wdata;
  logic [47:0] p;
  logic [15:0] douta;
  logic [1:0]  mem_addr;
  logic        tick;
  logic [15:0] disp;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [47:0] exp;
  } sb_t;
  sb_t sb[$];

  dsp_mem_datapath #(.TICK_COUNT(TC)) dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .A            (a),
    .B            (b),
    .C            (c),
    .D            (d),
    .carryin      (cin),
    .select       (sel),
    .mem_we       (we),
    .mem_wdata    (wdata),
    .P            (p),
    .douta        (douta),
    .mem_addr     (mem_addr),
    .tick         (tick),
    .display_value(disp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: each entry is due at the negedge two posedges after it was driven.
  always @(negedge clk) begin
    sb_t e;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("dsp_p", p, e.exp);
    end
  end

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < budget);
  endtask

  int          va[5] = '{5, 5, 5, 5, 127};
  int          vb[5] = '{6, 6, 6, 6, 255};
  int          vc[5] = '{7, 7, 7, 7, 127};
  int          vd[5] = '{3, 3, 3, 3, 127};
  int          vs[5] = '{0, 1, 2, 3, 3};
  int          ve[5] = '{37, 30, 8, 56, 64898};
  logic [15:0] words[4] = '{16'd1111, 16'd2222, 16'd3333, 16'd4444};

  initial begin
    int          n;
    int          addr_m;
    logic [15:0] exp_disp;

    a = '0; b = '0; c = '0; d = '0; cin = 1'b0; sel = '0; we = 1'b0; wdata = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_p",     p,               48'd0);
    chk("rst_douta", 48'(douta),      48'd0);
    chk("rst_addr",  48'(mem_addr),   48'd0);
    chk("rst_tick",  48'(tick),       48'd0);
    chk("rst_disp",  48'(disp),       48'd0);
    rst = 1'b0;

    // One mode per cycle, carryin held at 1 to show it only matters in mode 11.
    cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a   = 7'(va[i]);
      b   = 8'(vb[i]);
      c   = 7'(vc[i]);
      d   = 7'(vd[i]);
      sel = 2'(vs[i]);
      sb.push_back('{cyc + 2, 48'(ve[i])});
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("sb_drain_modes", 48'(sb.size()), 48'd0);
    chk("pre_rst_p", p, 48'd64898);

    // Mid-run reset: counter is mid-period and P is nonzero.
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_p",     p,             48'd0);
    chk("mid_rst_douta", 48'(douta),    48'd0);
    chk("mid_rst_addr",  48'(mem_addr), 48'd0);
    chk("mid_rst_tick",  48'(tick),     48'd0);
    chk("mid_rst_disp",  48'(disp),     48'd0);

    @(negedge clk);
    a = 7'd12; b = 8'd10; c = 7'd4; d = 7'd0; cin = 1'b0; sel = 2'b00;
    rst = 1'b0;
    wait_tick(3 * TC, n);
    chk("first_tick_cycles", 48'(n),        48'(TC - 1));
    chk("pre_tick_disp",     48'(disp),     48'd0);
    chk("pre_tick_addr",     48'(mem_addr), 48'd0);
    chk("tick_p",            p,             48'd124);
    @(negedge clk);
`ifndef DISPLAY_MEM_SOURCE_EN
    chk("tick_latch_disp", 48'(disp), 48'd124);
`endif
    chk("tick_addr_inc", 48'(mem_addr), 48'd1);
    chk("tick_one_cycle", 48'(tick),   48'd0);

    wait_tick(3 * TC, n);
    chk("tick_period", 48'(n), 48'(TC - 1));
    @(negedge clk);
    chk("addr_two", 48'(mem_addr), 48'd2);

    // Writes land in tick cycles, starting at address 2.
    addr_m = 2;
    for (int i = 0; i < 4; i++) begin
      wait_tick(3 * TC, n);
      chk("wr_period", 48'(n), 48'(TC - 1));
      we    = 1'b1;
      wdata = words[addr_m];
      @(negedge clk);
      we     = 1'b0;
      addr_m = (addr_m + 1) % 4;
      chk("wr_addr", 48'(mem_addr), 48'(addr_m));
    end

    for (int i = 0; i < 4; i++) begin
      wait_tick(3 * TC, n);
      chk("rd_douta", 48'(douta), 48'(words[addr_m]));
`ifdef DISPLAY_MEM_SOURCE_EN
      exp_disp = words[addr_m];
`else
      exp_disp = 16'd124;
`endif
      @(negedge clk);
      chk("rd_disp", 48'(disp), 48'(exp_disp));
      addr_m = (addr_m + 1) % 4;
      chk("rd_addr", 48'(mem_addr), 48'(addr_m));
    end

    chk("sb_empty_end", 48'(sb.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
